button_bounce_gen: RTL and testbench



---
 rtl/button_bounce_pkg.sv | 22 ++
 rtl/lfsr16.sv | 24 ++
 rtl/button_bounce_gen.sv | 140 ++++++++++++++
 tb/tb_button_bounce_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/button_bounce_pkg.sv
// Shared types and constants for the bouncing-pushbutton emulator.
package button_bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is swapped for this
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock, never stalls.
module lfsr16
  import button_bounce_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic [15:0] state_o
);

  localparam logic [15:0] SEED_EFF = seed_fix(SEED);

  logic [15:0] state_q;

  // State register: reload the (zero-safe) seed on reset, otherwise step
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= SEED_EFF;
    else        state_q <= lfsr_step(state_q);
  end

  assign state_o = state_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Bouncing-pushbutton emulator: turns a clean commanded level into a pin
// waveform with pseudo-random contact bounce, then forces a clean settle.
// Optional macro BUTTON_BOUNCE_TOGGLE_COUNT_EN adds toggle_cnt, the number of
// raw toggles seen in the current/last bounce window (saturating at 255).
module button_bounce_gen
  import button_bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 1000,
  parameter int unsigned GAP_W         = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       active_low,
  input  logic       cmd_level,
  output logic       bounce_out,
  output logic       busy,
  output logic       settled_level
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
  , output logic [7:0] toggle_cnt
`endif
);

  localparam int unsigned TW = $clog2(BOUNCE_CYCLES);
  localparam logic [TW-1:0] TOT_INIT = TW'(BOUNCE_CYCLES - 1);

  state_e             state_q, state_d;
  logic               target_q, target_d;
  logic               raw_q, raw_d;
  logic               settled_q, settled_d;
  logic [TW-1:0]      tot_q, tot_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tgl_ev, clr_ev;
  logic [15:0]        lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .n_rst   (n_rst),
    .state_o (lfsr)
  );

  // Only the low GAP_W bits feed the gap counter
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr;

  // Next-state: first contact on a commanded edge, random toggles while
  // bouncing, restart on a new command, forced settle when the window ends
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    raw_d     = raw_q;
    settled_d = settled_q;
    tot_d     = tot_q;
    gap_d     = gap_q;
    tgl_ev    = 1'b0;
    clr_ev    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_level != target_q) begin
          target_d = cmd_level;
          state_d  = BOUNCE;
          raw_d    = ~raw_q;
          tot_d    = TOT_INIT;
          gap_d    = lfsr[GAP_W-1:0];
          tgl_ev   = 1'b1;
          clr_ev   = 1'b1;
        end
      end
      BOUNCE: begin
        tot_d = tot_q - 1'b1;
        if (gap_q == '0) begin
          raw_d  = ~raw_q;
          gap_d  = lfsr[GAP_W-1:0];
          tgl_ev = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
        // A new command restarts the window even if it was about to expire
        if (cmd_level != target_q) begin
          target_d = cmd_level;
          tot_d    = TOT_INIT;
          clr_ev   = 1'b1;
        end else if (tot_q == '0) begin
          raw_d     = target_q;
          settled_d = target_q;
          state_d   = IDLE;
          tot_d     = '0;
          tgl_ev    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset shows a released button at either polarity
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      raw_q     <= 1'b0;
      settled_q <= 1'b0;
      tot_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      raw_q     <= raw_d;
      settled_q <= settled_d;
      tot_q     <= tot_d;
      gap_q     <= gap_d;
    end
  end

  assign bounce_out    = raw_q ^ active_low;
  assign busy          = (state_q == BOUNCE);
  assign settled_level = settled_q;

`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Toggle counter: restarts on window entry/restart, saturates at 255
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ev)                          cnt_d = {7'd0, tgl_ev};
    else if (tgl_ev && cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
  end

  // Toggle counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign toggle_cnt = cnt_q;
`else
  logic unused_ev;
  assign unused_ev = tgl_ev ^ clr_ev;
`endif

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: default instance plus a minimal
// BOUNCE_CYCLES=2 / GAP_W=1 instance sharing clock, reset and polarity.
module tb_button_bounce_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst, active_low, cmd_level, cmd2;
  logic bounce_out, busy, settled_level;
  logic bo2, busy2, set2;
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
  logic [7:0] toggle_cnt, tc2;
`endif

  int vecs = 0;
  int errs = 0;

  button_bounce_gen dut (
    .clk(clk), .n_rst(n_rst), .active_low(active_low), .cmd_level(cmd_level),
    .bounce_out(bounce_out), .busy(busy), .settled_level(settled_level)
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
    , .toggle_cnt(toggle_cnt)
`endif
  );

  button_bounce_gen #(.BOUNCE_CYCLES(2), .GAP_W(1)) dut2 (
    .clk(clk), .n_rst(n_rst), .active_low(active_low), .cmd_level(cmd2),
    .bounce_out(bo2), .busy(busy2), .settled_level(set2)
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
    , .toggle_cnt(tc2)
`endif
  );

  function automatic logic [15:0] gal(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [15:0] m;
    n_rst = 1'b0; active_low = 1'b1; cmd_level = 1'b0; cmd2 = 1'b0;
    repeat (3) tick();
    vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL rst_bounce: got %b want 1", bounce_out); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL rst_settled: got %b want 0", settled_level); end
    n_rst = 1'b1;
    m = 16'hACE1;
    vecs++; if (dut.lfsr !== m) begin errs++; $display("FAIL rst_lfsr: got %h want %h", dut.lfsr, m); end
    for (int i = 0; i < 50; i++) begin
      tick();
      m = gal(m);
      vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL idle_bounce[%0d]: got %b want 1", i, bounce_out); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy); end
      vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL idle_settled[%0d]: got %b want 0", i, settled_level); end
      vecs++; if (dut.lfsr !== m) begin errs++; $display("FAIL lfsr_seq[%0d]: got %h want %h", i, dut.lfsr, m); end
    end
  endtask

  task automatic test_press();
    int edges;
    logic prev;
    active_low = 1'b0;
    tick();
    vecs++; if (bounce_out !== 1'b0) begin errs++; $display("FAIL pol_flip: got %b want 0", bounce_out); end
    cmd_level = 1'b1;
    edges = 0; prev = bounce_out;
    for (int k = 1; k <= 1001; k++) begin
      tick();
      if (k == 1) begin
        vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL press_first: got %b want 1", bounce_out); end
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
        vecs++; if (toggle_cnt !== 8'd1) begin errs++; $display("FAIL press_cnt1: got %0d want 1", toggle_cnt); end
`endif
      end
      if (k <= 1000) begin
        if (bounce_out !== prev) edges++;
        prev = bounce_out;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL press_busy[%0d]: got %b want 1", k, busy); end
      end
      if (k == 1000) begin
        vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL press_early: got %b want 0", settled_level); end
      end
    end
    vecs++; if (settled_level !== 1'b1) begin errs++; $display("FAIL press_settled: got %b want 1", settled_level); end
    vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL press_final: got %b want 1", bounce_out); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL press_done: got %b want 0", busy); end
    vecs++; if (edges < 2) begin errs++; $display("FAIL press_edges: got %0d want >=2", edges); end
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
    vecs++; if (toggle_cnt !== 8'((edges > 255) ? 255 : edges)) begin errs++; $display("FAIL press_cnt: got %0d want %0d", toggle_cnt, edges); end
`endif
  endtask

  task automatic test_release();
    cmd_level = 1'b0;
    for (int k = 1; k <= 1001; k++) begin
      tick();
      if (k == 1000) begin
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rel_busy: got %b want 1", busy); end
        vecs++; if (settled_level !== 1'b1) begin errs++; $display("FAIL rel_early: got %b want 1", settled_level); end
      end
    end
    vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL rel_settled: got %b want 0", settled_level); end
    vecs++; if (bounce_out !== 1'b0) begin errs++; $display("FAIL rel_final: got %b want 0", bounce_out); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rel_done: got %b want 0", busy); end
  endtask

  task automatic test_restart();
    int edges;
    logic prev;
    tick();
    cmd_level = 1'b1;
    edges = 0; prev = bounce_out;
    for (int k = 1; k <= 1401; k++) begin
      tick();
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
      if (k == 1) begin
        vecs++; if (toggle_cnt !== 8'd1) begin errs++; $display("FAIL rs_cnt_clr: got %0d want 1", toggle_cnt); end
      end
`endif
      if (k <= 1400) begin
        if (k >= 401 && bounce_out !== prev) edges++;
        prev = bounce_out;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rs_busy[%0d]: got %b want 1", k, busy); end
        vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL rs_settled[%0d]: got %b want 0", k, settled_level); end
      end
      if (k == 400) cmd_level = 1'b0;
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rs_done: got %b want 0", busy); end
    vecs++; if (bounce_out !== 1'b0) begin errs++; $display("FAIL rs_final: got %b want 0", bounce_out); end
    vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL rs_settle: got %b want 0", settled_level); end
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
    vecs++; if (toggle_cnt !== 8'((edges > 255) ? 255 : edges)) begin errs++; $display("FAIL rs_cnt: got %0d want %0d", toggle_cnt, edges); end
`endif
  endtask

  task automatic test_reset_mid();
    active_low = 1'b1;
    tick();
    vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL mid_pre: got %b want 1", bounce_out); end
    cmd_level = 1'b1;
    repeat (300) tick();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b want 1", busy); end
    n_rst = 1'b0;
    #1;
    vecs++; if (bounce_out !== 1'b1) begin errs++; $display("FAIL mid_bounce: got %b want 1", bounce_out); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy0: got %b want 0", busy); end
    vecs++; if (settled_level !== 1'b0) begin errs++; $display("FAIL mid_settled: got %b want 0", settled_level); end
`ifdef BUTTON_BOUNCE_TOGGLE_COUNT_EN
    vecs++; if (toggle_cnt !== 8'd0) begin errs++; $display("FAIL mid_cnt: got %0d want 0", toggle_cnt); end
`endif
    repeat (2) tick();
    n_rst = 1'b1; cmd_level = 1'b0;
    vecs++; if (dut.lfsr !== 16'hACE1) begin errs++; $display("FAIL mid_lfsr: got %h want ace1", dut.lfsr); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_idle: got %b want 0", busy); end
  endtask

  task automatic test_short();
    active_low = 1'b0;
    tick();
    cmd2 = 1'b1;
    tick();
    vecs++; if (bo2 !== 1'b1) begin errs++; $display("FAIL sh_first: got %b want 1", bo2); end
    vecs++; if (busy2 !== 1'b1) begin errs++; $display("FAIL sh_busy1: got %b want 1", busy2); end
    tick();
    vecs++; if (busy2 !== 1'b1) begin errs++; $display("FAIL sh_busy2: got %b want 1", busy2); end
    vecs++; if (set2 !== 1'b0) begin errs++; $display("FAIL sh_early: got %b want 0", set2); end
    tick();
    vecs++; if (busy2 !== 1'b0) begin errs++; $display("FAIL sh_done: got %b want 0", busy2); end
    vecs++; if (set2 !== 1'b1) begin errs++; $display("FAIL sh_settled: got %b want 1", set2); end
    vecs++; if (bo2 !== 1'b1) begin errs++; $display("FAIL sh_final: got %b want 1", bo2); end
    cmd2 = 1'b0;
    tick();
    vecs++; if (bo2 !== 1'b0) begin errs++; $display("FAIL shr_first: got %b want 0", bo2); end
    tick();
    vecs++; if (busy2 !== 1'b1) begin errs++; $display("FAIL shr_busy: got %b want 1", busy2); end
    tick();
    vecs++; if (busy2 !== 1'b0) begin errs++; $display("FAIL shr_done: got %b want 0", busy2); end
    vecs++; if (set2 !== 1'b0) begin errs++; $display("FAIL shr_settled: got %b want 0", set2); end
    vecs++; if (bo2 !== 1'b0) begin errs++; $display("FAIL shr_final: got %b want 0", bo2); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_restart();
    test_reset_mid();
    test_short();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
